// File: rtl/contador_bcd_n.sv
// contador_bcd_n: N-digit up/down BCD counter with programmable terminal
// value, wrap/saturate boundaries, parallel load and low-count auto-reload.
// Single clock domain; every output is registered.

// One BCD digit of the step chain: +1/-1 when cin is set, ripples carry/borrow.
module contador_bcd_digito (
  input  logic       inc,
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);
  // Digit step: 9->0 carries going up, 0->9 borrows going down.
  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (cin) begin
      if (inc) begin
        cout = (d == 4'd9);
        nxt  = cout ? 4'd0 : d + 4'd1;
      end else begin
        cout = (d == 4'd0);
        nxt  = cout ? 4'd9 : d - 4'd1;
      end
    end
  end
endmodule

module contador_bcd_n #(
  parameter int DIGITOS   = 2,
  parameter int MAX       = 99,
  parameter int MODO      = 0,
  parameter int REPOR_LIM = 5,
  parameter int REPOR_VAL = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 inc,
  input  logic                 carga,
  input  logic [4*DIGITOS-1:0] valor_carga,
  input  logic                 auto_repor,
  output logic [4*DIGITOS-1:0] valor,
  output logic                 eh_max,
  output logic                 eh_zero,
  output logic                 fim,
  output logic                 erro
);
  localparam int W = 4*DIGITOS;

  // Decimal integer -> packed BCD, nibble 0 = units.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITOS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Valid BCD vectors order the same way as their decimal values, so all
  // limit comparisons are done directly on the BCD encoding.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX);
  localparam logic [W-1:0] LIM_BCD = to_bcd(REPOR_LIM);
  localparam logic [W-1:0] VAL_BCD = to_bcd(REPOR_VAL);

  if (DIGITOS < 1 || DIGITOS > 4) begin : g_err_dig
    $error("contador_bcd_n: DIGITOS must be 1..4");
  end
  if (MAX < 1 || MAX > 10**DIGITOS - 1) begin : g_err_max
    $error("contador_bcd_n: MAX out of range for DIGITOS");
  end
  if (MODO != 0 && MODO != 1) begin : g_err_modo
    $error("contador_bcd_n: MODO must be 0 or 1");
  end
  if (REPOR_VAL > MAX || REPOR_VAL < REPOR_LIM || REPOR_LIM < 0) begin : g_err_repor
    $error("contador_bcd_n: need REPOR_LIM <= REPOR_VAL <= MAX");
  end

  logic [W-1:0]     passo;
  logic [DIGITOS:0] carry;
  logic             borda;
  logic             carga_ok;
  logic [W-1:0]     valor_nxt;
  logic             fim_nxt;
  logic             erro_nxt;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
    contador_bcd_digito u_dig (
      .inc  (inc),
      .d    (valor[4*g +: 4]),
      .cin  (carry[g]),
      .nxt  (passo[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  // Borrow out of the top digit means every digit was 0; up-limit is MAX,
  // which need not be all nines.
  assign borda = inc ? (valor == MAX_BCD) : carry[DIGITOS];

  // Load accepted only for well-formed BCD not above MAX.
  always_comb begin
    carga_ok = (valor_carga <= MAX_BCD);
    for (int i = 0; i < DIGITOS; i++)
      if (valor_carga[4*i +: 4] > 4'd9) carga_ok = 1'b0;
  end

  // Next state: carga > auto-reload > step > hold (reset handled in the flop).
  always_comb begin
    valor_nxt = valor;
    fim_nxt   = 1'b0;
    erro_nxt  = 1'b0;
    if (carga) begin
      if (carga_ok) valor_nxt = valor_carga;
      else          erro_nxt  = 1'b1;
    end else if (auto_repor && (REPOR_LIM > 0) && (valor < LIM_BCD)) begin
      valor_nxt = VAL_BCD;
    end else if (en) begin
      if (borda) begin
        fim_nxt = 1'b1;
        if (MODO == 0) valor_nxt = inc ? '0 : MAX_BCD;
      end else begin
        valor_nxt = passo;
      end
    end
  end

  // State and flags registered together so the flags never glitch against valor.
  always_ff @(posedge clock) begin
    if (reset) begin
      valor   <= '0;
      fim     <= 1'b0;
      erro    <= 1'b0;
      eh_max  <= 1'b0;
      eh_zero <= 1'b1;
    end else begin
      valor   <= valor_nxt;
      fim     <= fim_nxt;
      erro    <= erro_nxt;
      eh_max  <= (valor_nxt == MAX_BCD);
      eh_zero <= (valor_nxt == '0);
    end
  end
endmodule

// File: tb/tb_contador_bcd_n.sv
// Directed bench for contador_bcd_n: three instances (default wrap, saturate,
// MAX=59) share one stimulus stream; each check names the instance it targets.
module tb_contador_bcd_n;
  logic       clock = 1'b0;
  logic       reset, en, inc, carga, auto_repor;
  logic [7:0] valor_carga;

  logic [7:0] va, vs, vf;
  logic       mxa, mxs, mxf, zra, zrs, zrf, fma, fms, fmf, era, ers, erf;

  int ncmp = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  contador_bcd_n u_dut (
    .clock(clock), .reset(reset), .en(en), .inc(inc), .carga(carga),
    .valor_carga(valor_carga), .auto_repor(auto_repor),
    .valor(va), .eh_max(mxa), .eh_zero(zra), .fim(fma), .erro(era));

  contador_bcd_n #(.MODO(1)) u_sat (
    .clock(clock), .reset(reset), .en(en), .inc(inc), .carga(carga),
    .valor_carga(valor_carga), .auto_repor(auto_repor),
    .valor(vs), .eh_max(mxs), .eh_zero(zrs), .fim(fms), .erro(ers));

  contador_bcd_n #(.MAX(59)) u_m59 (
    .clock(clock), .reset(reset), .en(en), .inc(inc), .carga(carga),
    .valor_carga(valor_carga), .auto_repor(auto_repor),
    .valor(vf), .eh_max(mxf), .eh_zero(zrf), .fim(fmf), .erro(erf));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    carga = 1'b1; valor_carga = v; en = 1'b0;
    step();
    carga = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [12];
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    reset = 1'b1; en = 1'b0; inc = 1'b1; carga = 1'b0;
    auto_repor = 1'b0; valor_carga = 8'h00;
    #2;

    // Reset state
    step();
    chk("rst valor", va, 8'h00);
    chk("rst eh_zero", {7'd0, zra}, 8'd1);
    chk("rst eh_max", {7'd0, mxa}, 8'd0);
    chk("rst fim", {7'd0, fma}, 8'd0);
    chk("rst erro", {7'd0, era}, 8'd0);

    // Count up 12 clocks with decimal carry
    reset = 1'b0; en = 1'b1; inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up valor", va, seq[i]);
      chk("up fim", {7'd0, fma}, 8'd0);
    end
    chk("up eh_zero", {7'd0, zra}, 8'd0);

    // Load 0x98: accepted at MAX 99, rejected at MAX 59
    load(8'h98);
    chk("ld98 valor", va, 8'h98);
    chk("ld98 erro", {7'd0, era}, 8'd0);
    chk("ld98 m59 valor", vf, 8'h12);
    chk("ld98 m59 erro", {7'd0, erf}, 8'd1);

    // Up across MAX: wrap vs saturate
    en = 1'b1; inc = 1'b1;
    step();
    chk("wrap 99", va, 8'h99);
    chk("wrap eh_max", {7'd0, mxa}, 8'd1);
    chk("wrap fim0", {7'd0, fma}, 8'd0);
    chk("sat 99", vs, 8'h99);
    chk("m59 erro clr", {7'd0, erf}, 8'd0);
    step();
    chk("wrap 00", va, 8'h00);
    chk("wrap fim", {7'd0, fma}, 8'd1);
    chk("wrap eh_zero", {7'd0, zra}, 8'd1);
    chk("sat hold", vs, 8'h99);
    chk("sat fim", {7'd0, fms}, 8'd1);
    step();
    chk("wrap 01", va, 8'h01);
    chk("wrap fim off", {7'd0, fma}, 8'd0);
    chk("sat hold2", vs, 8'h99);
    chk("sat fim2", {7'd0, fms}, 8'd1);

    // Down across zero
    load(8'h00);
    chk("ld00 erro", {7'd0, era}, 8'd0);
    en = 1'b1; inc = 1'b0;
    step();
    chk("dn wrap", va, 8'h99);
    chk("dn wrap fim", {7'd0, fma}, 8'd1);
    chk("dn sat", vs, 8'h00);
    chk("dn sat fim", {7'd0, fms}, 8'd1);
    chk("dn m59", vf, 8'h59);
    chk("dn m59 fim", {7'd0, fmf}, 8'd1);
    chk("dn m59 eh_max", {7'd0, mxf}, 8'd1);

    // Non-decimal limit 59
    load(8'h58);
    en = 1'b1; inc = 1'b1;
    step();
    chk("m59 59", vf, 8'h59);
    chk("m59 eh_max", {7'd0, mxf}, 8'd1);
    chk("d99 eh_max at59", {7'd0, mxa}, 8'd0);
    step();
    chk("m59 wrap", vf, 8'h00);
    chk("m59 fim", {7'd0, fmf}, 8'd1);
    chk("m59 eh_max off", {7'd0, mxf}, 8'd0);
    chk("m59 eh_zero", {7'd0, zrf}, 8'd1);
    chk("d99 60", va, 8'h60);
    chk("d99 fim 60", {7'd0, fma}, 8'd0);

    // Load accept / reject
    load(8'h42);
    chk("ld42", va, 8'h42);
    load(8'h4A);
    chk("ld4A hold", va, 8'h42);
    chk("ld4A erro", {7'd0, era}, 8'd1);
    step();
    chk("erro pulse", {7'd0, era}, 8'd0);
    load(8'h60);
    chk("ld60 d99", va, 8'h60);
    chk("ld60 m59 hold", vf, 8'h42);
    chk("ld60 m59 erro", {7'd0, erf}, 8'd1);
    carga = 1'b1; valor_carga = 8'h37; en = 1'b1; inc = 1'b1;
    step();
    carga = 1'b0;
    chk("ld+en", va, 8'h37);

    // Auto-reload below 5
    load(8'h06);
    auto_repor = 1'b1; en = 1'b1; inc = 1'b0;
    step();
    chk("ar 05", va, 8'h05);
    step();
    chk("ar 04", va, 8'h04);
    chk("ar fim04", {7'd0, fma}, 8'd0);
    step();
    chk("ar 25", va, 8'h25);
    chk("ar fim25", {7'd0, fma}, 8'd0);
    step();
    chk("ar 24", va, 8'h24);
    carga = 1'b1; valor_carga = 8'h00;
    step();
    carga = 1'b0;
    chk("ar ld00", va, 8'h00);
    step();
    chk("ar beats wrap", va, 8'h25);
    chk("ar no fim", {7'd0, fma}, 8'd0);
    chk("ar sat", vs, 8'h25);
    load(8'h03);
    chk("ar ld03", va, 8'h03);
    step();
    chk("ar en0", va, 8'h25);

    // Reset beats everything
    auto_repor = 1'b0;
    load(8'h37);
    reset = 1'b1; carga = 1'b1; valor_carga = 8'h4A; auto_repor = 1'b1; en = 1'b1;
    step();
    chk("rp valor", va, 8'h00);
    chk("rp eh_zero", {7'd0, zra}, 8'd1);
    chk("rp fim", {7'd0, fma}, 8'd0);
    chk("rp erro", {7'd0, era}, 8'd0);

    // Hold with en low
    reset = 1'b0; carga = 1'b0; auto_repor = 1'b0; en = 1'b0;
    load(8'h15);
    step();
    chk("hold", va, 8'h15);
    chk("hold fim", {7'd0, fma}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
